// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and instruction/PC constants for the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_STEP      = 32'd4;
endpackage

// File: rtl/fetch_imm_split.sv
// fetch_imm_split: extracts raw I-type and B-type immediate fields from an instruction word.
module fetch_imm_split (
    input  logic [31:0] i_instr,
    output logic [11:0] o_i_imm,
    output logic [11:0] o_b_imm
);
    assign o_i_imm = i_instr[31:20];
    assign o_b_imm = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]};
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with one held instruction,
// branch redirect, misaligned-target flag and terminal halt on EBREAK.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [11:0] I_immediate,
    output logic [11:0] B_immediate,
    output logic        halted,
    output logic        misalign_err
);
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_instr, w_sum;
    logic        r_misalign, w_load, w_advance;

    assign w_load    = (r_state == FETCH) && imem_ack;
    assign w_advance = (r_state == VALID) && !stall;
    assign w_sum     = r_pc + (branch_taken ? branch_offset : PC_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_load)
            w_next = (HALT_ON_EBREAK && imem_rdata == INSTR_EBREAK) ? HALT : VALID;
        else if (w_advance)
            w_next = FETCH;
    end

    // Misaligned targets are truncated to a word boundary; the flag records that it happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= INSTR_NOP;
            r_misalign <= 1'b0;
        end else begin
            if (w_load) r_instr <= imem_rdata;
            if (w_advance) begin
                r_pc <= {w_sum[31:2], 2'b00};
                if (|w_sum[1:0]) r_misalign <= 1'b1;
            end
        end
    end

    assign imem_req     = (r_state == FETCH);
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = (r_state == VALID);
    assign halted       = (r_state == HALT);
    assign misalign_err = r_misalign;

    fetch_imm_split u_imm (
        .i_instr (r_instr),
        .o_i_imm (I_immediate),
        .o_b_imm (B_immediate)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic against a transaction-level fetch model.
module tb_instr_fetch;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic [31:0] pc, instr;
    logic        instr_valid, halted, misalign_err;
    logic [11:0] I_immediate, B_immediate;

    int n_total = 0;
    int n_bad   = 0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .pc(pc),
        .instr(instr), .instr_valid(instr_valid), .I_immediate(I_immediate),
        .B_immediate(B_immediate), .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Model: the fetcher is either waiting for memory, holding a word, or halted.
    typedef enum int {WAITING, HOLDING, HALTED} mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_instr;
    logic        m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= WAITING;
            m_pc    <= 32'h0;
            m_instr <= NOP;
            m_mis   <= 1'b0;
        end else if (m_mode == WAITING && imem_ack) begin
            m_instr <= imem_rdata;
            m_mode  <= (imem_rdata == EBREAK) ? HALTED : HOLDING;
        end else if (m_mode == HOLDING && !stall) begin
            logic [31:0] target;
            target = m_pc + (branch_taken ? branch_offset : 32'd4);
            if (target % 4 != 0) m_mis <= 1'b1;
            m_pc   <= target & ~32'd3;
            m_mode <= WAITING;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        e = m_instr;
        chk("imem_req", 32'(imem_req), 32'(m_mode == WAITING));
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("instr", instr, m_instr);
        chk("instr_valid", 32'(instr_valid), 32'(m_mode == HOLDING));
        chk("halted", 32'(halted), 32'(m_mode == HALTED));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        chk("I_immediate", 32'(I_immediate), 32'(e[31:20]));
        chk("B_immediate", 32'(B_immediate), 32'({e[31], e[7], e[30:25], e[11:8]}));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] w);
        imem_ack = 1'b1;
        imem_rdata = w;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic advance(input logic bt, input logic [31:0] off);
        stall = 1'b0;
        branch_taken = bt;
        branch_offset = off;
        step();
        branch_taken = 1'b0;
    endtask

    initial begin
        logic [31:0] hold_pc, hold_instr;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) step();
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wait_addr", imem_addr, 32'h0);
            chk("wait_req", 32'(imem_req), 32'd1);
        end
        fetch_word(32'h0050_0093);
        chk("s1_valid", 32'(instr_valid), 32'd1);
        chk("s1_instr", instr, 32'h0050_0093);
        chk("s1_iimm", 32'(I_immediate), 32'h005);
        advance(1'b1, 32'h100);
        chk("to_100", imem_addr, 32'h100);
        fetch_word(32'h1234_5678);
        advance(1'b1, 32'hFFFF_FFF8);
        chk("br_back", imem_addr, 32'h0F8);
        fetch_word(32'hFE00_0EE3);
        hold_pc = pc;
        hold_instr = instr;
        stall = 1'b1;
        branch_offset = 32'h40;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i % 2 == 0);
            step();
            chk("stall_pc", pc, hold_pc);
            chk("stall_instr", instr, hold_instr);
            chk("stall_valid", 32'(instr_valid), 32'd1);
        end
        branch_taken = 1'b0;
        advance(1'b1, 32'hFFFF_FF04);
        chk("to_top", pc, 32'hFFFF_FFFC);
        fetch_word(32'h0000_0013);
        advance(1'b0, 32'h0);
        chk("wrap", pc, 32'h0);
        chk("no_mis", 32'(misalign_err), 32'd0);
        fetch_word(32'h0000_0013);
        advance(1'b1, 32'h6);
        chk("mis_pc", pc, 32'h4);
        chk("mis_set", 32'(misalign_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            fetch_word(32'h0000_0013);
            advance(1'b0, 32'h0);
        end
        chk("mis_sticky", 32'(misalign_err), 32'd1);
        hold_pc = pc;
        fetch_word(EBREAK);
        imem_ack = 1'b1;
        imem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_pc", pc, hold_pc);
            chk("halt_instr", instr, EBREAK);
        end
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'd1);
        chk("async_pc", pc, 32'h0);
        chk("async_halt", 32'(halted), 32'd0);
        chk("async_mis", 32'(misalign_err), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                imem_ack = 1'b1;
                step();
                step();
                rst_n = 1'b1;
            end
            imem_ack = ($urandom_range(0, 2) == 0);
            imem_rdata = ($urandom_range(0, 29) == 0) ? EBREAK : $urandom;
            stall = ($urandom_range(0, 2) == 0);
            branch_taken = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: branch_offset = $urandom;
                1: branch_offset = 32'($urandom_range(0, 255)) << 2;
                2: branch_offset = -(32'($urandom_range(0, 255)) << 2);
                default: branch_offset = 32'($urandom_range(0, 15));
            endcase
            step();
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
